hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core. It owns the PC-write enable, the IF/ID write/flush controls and the ID/EX bubble. It resolves, per cycle, three sources: taken-branch flush, load-use stall, and instruction-memory wait states. It also keeps stall/flush event counters and a sticky instruction-fetch timeout flag.

Parameters:
LOAD_BUBBLES, 1, number of bubbles inserted per load-use hazard (1..7)
IMEM_TIMEOUT, 255, consecutive imem_ready=0 cycles before imem_error sets (1..65535)
CNT_W, 16, width of the stall_count and flush_count counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
if_id_rs  in  5  rs field of the instruction held in IF/ID
if_id_rt  in  5  rt field of the instruction held in IF/ID
if_id_uses_rt  in  1  IF/ID instruction reads rt as a source
id_ex_mem_read  in  1  instruction in ID/EX is a load
id_ex_rt  in  5  destination register of the load in ID/EX
branch_taken  in  1  branch/jump resolved taken in EX this cycle
imem_ready  in  1  instruction memory returns valid data this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  load NOP (32'h0) into IF/ID; overrides if_id_write
id_ex_bubble  out  1  zero the control fields entering ID/EX
imem_error  out  1  sticky fetch-timeout flag
stall_count  out  CNT_W  cycles with pc_write=0 since reset, saturating
flush_count  out  CNT_W  taken-branch flushes since reset, saturating

Behaviour:
- Reset: reset sampled low at a rising clk edge -> state=RUN, bubble_cnt=0, wait_cnt=0, imem_error=0, stall_count=0, flush_count=0. While reset is low, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1. Reset mid-stall aborts the stall immediately with no residual bubbles.
- Control outputs are combinational from state and inputs (zero latency). State, counters and imem_error are registered.
- hazard = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & id_ex_rt == if_id_rt)).
- Priority: branch_taken > load-use (hazard or LOAD_STALL) > imem wait > run.
- State RUN:
  - branch_taken=1 -> pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_count+1; stay in RUN.
  - else hazard=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_BUBBLES>1, go to LOAD_STALL with bubble_cnt=LOAD_BUBBLES-1; otherwise stay in RUN.
  - else imem_ready=0 -> pc_write=0, if_id_flush=1, id_ex_bubble=0; wait_cnt+1; go to IMEM_WAIT.
  - else all enables=1, flush=0, bubble=0; wait_cnt=0.
- State LOAD_STALL:
  - Outputs as for a hazard stall; bubble_cnt-1; return to RUN when bubble_cnt reaches 0 this cycle.
  - branch_taken=1 -> branch outputs apply, bubble_cnt=0, go to RUN.
- State IMEM_WAIT:
  - Outputs as for the imem-wait case while imem_ready=0; wait_cnt increments, saturating at IMEM_TIMEOUT.
  - wait_cnt reaching IMEM_TIMEOUT sets imem_error (sticky until reset). The core keeps waiting.
  - imem_ready=1 -> RUN outputs this cycle, wait_cnt=0, go to RUN.
  - branch_taken=1 -> branch outputs apply, go to RUN, wait_cnt=0.
- stall_count increments in every non-reset cycle with pc_write=0.
- Both counters saturate at all-ones and never wrap.
- Simultaneous hazard and imem_ready=0: the load-use stall wins. wait_cnt is unchanged that cycle.

Decomposition:
- Package mips_pkg: state enum {RUN, LOAD_STALL, IMEM_WAIT}, REG_ZERO=5'd0, NOP_INSTR=32'h0.
- One sub-module, sat_counter (parameter W; inputs inc, clear; output count), instanced for stall_count and flush_count.

Test Plan:
- Reset held low for 3 cycles, then released -> during reset pc_write=0, if_id_flush=1, id_ex_bubble=1; after release, counters=0 and pc_write=1.
- id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8, LOAD_BUBBLES=2 -> 2 cycles with pc_write=0 and id_ex_bubble=1, then run; stall_count=2. Repeating with id_ex_rt=0 -> no stall.
- branch_taken=1 while in LOAD_STALL -> same cycle pc_write=1, if_id_flush=1, id_ex_bubble=1; next cycle state=RUN; flush_count=1.
- imem_ready=0 for 5 cycles with IMEM_TIMEOUT=3 -> if_id_flush=1 for 5 cycles and imem_error=1 from the 3rd wait cycle; imem_error stays 1 after imem_ready returns, until reset.
- Hazard and imem_ready=0 in the same cycle -> id_ex_bubble=1, if_id_write=0, if_id_flush=0.
- CNT_W=4 with 20 stall cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the 5-stage MIPS core's
//                hazard and sequencing control.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Sequencing states of the hazard controller
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        IMEM_WAIT  = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Load-use hazard: the load in ID/EX writes a register the IF/ID
    // instruction is about to read. $zero never creates a dependency.
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] load_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (load_rt != REG_ZERO) &&
               ((load_rt == rs) || (uses_rt && (load_rt == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at all-ones instead of wrapping.
//                clear has priority over inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Count qualifying events, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard/sequencing controller. Resolves taken-branch
//                flush, load-use stall and instruction-memory wait states
//                into PC / IF/ID / ID/EX controls, counts stall and flush
//                events, and flags fetch timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int IMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             imem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              c_WAIT_W    = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(IMEM_TIMEOUT);
    localparam logic [2:0]      c_BUB_INIT  = 3'(LOAD_BUBBLES - 1);

    localparam logic [1:0] c_ST_RUN   = RUN;
    localparam logic [1:0] c_ST_LOAD  = LOAD_STALL;
    localparam logic [1:0] c_ST_IWAIT = IMEM_WAIT;

    logic [1:0]          r_state;
    logic [2:0]          r_bub_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_imem_error;

    logic [1:0]          w_state_nxt;
    logic [2:0]          w_bub_nxt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                w_err_nxt;
    logic                w_hazard;
    logic                w_pc_write;
    logic                w_if_id_write;
    logic                w_if_id_flush;
    logic                w_id_ex_bubble;

    // Per-cycle resolution: branch beats load-use, which beats imem wait
    always_comb begin
        w_hazard       = is_load_use(id_ex_mem_read, id_ex_rt, if_id_rs,
                                     if_id_rt, if_id_uses_rt);
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_state_nxt    = r_state;
        w_bub_nxt      = r_bub_cnt;
        w_wait_nxt     = r_wait_cnt;
        w_err_nxt      = r_imem_error;

        if (branch_taken) begin
            // Squash the wrong-path fetch and the instruction behind the branch
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_state_nxt    = c_ST_RUN;
            w_bub_nxt      = 3'd0;
            w_wait_nxt     = '0;
        end else if (w_hazard || (r_state == c_ST_LOAD)) begin
            // Freeze PC and IF/ID, inject a bubble; wait_cnt is untouched
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
            if (r_state == c_ST_LOAD) begin
                w_bub_nxt = r_bub_cnt - 3'd1;
                if (w_bub_nxt == 3'd0) begin
                    w_state_nxt = c_ST_RUN;
                end
            end else if (LOAD_BUBBLES > 1) begin
                w_bub_nxt   = c_BUB_INIT;
                w_state_nxt = c_ST_LOAD;
            end else begin
                w_state_nxt = c_ST_RUN;
            end
        end else if (!imem_ready) begin
            // No valid fetch: hold PC and load a NOP into IF/ID
            w_pc_write    = 1'b0;
            w_if_id_flush = 1'b1;
            w_state_nxt   = c_ST_IWAIT;
            if (r_wait_cnt != c_WAIT_MAX) begin
                w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
            end
            if (w_wait_nxt == c_WAIT_MAX) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            w_state_nxt = c_ST_RUN;
            w_wait_nxt  = '0;
        end
    end

    // Reset forces a safe pipeline: nothing advances, everything is squashed
    always_comb begin
        pc_write     = reset & w_pc_write;
        if_id_write  = reset & w_if_id_write;
        if_id_flush  = ~reset | w_if_id_flush;
        id_ex_bubble = ~reset | w_id_ex_bubble;
    end

    // Sequencing state, bubble/wait counters and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_RUN;
            r_bub_cnt    <= 3'd0;
            r_wait_cnt   <= '0;
            r_imem_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bub_cnt    <= w_bub_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_imem_error <= w_err_nxt;
        end
    end

    assign imem_error = r_imem_error;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (~reset),
        .inc   (~w_pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (~reset),
        .inc   (branch_taken),
        .count (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed scenarios
//                followed by random traffic, all compared every cycle
//                against an event-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int LB   = 2;
    localparam int TO   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    if_id_rs;
    logic [4:0]    if_id_rt;
    logic          if_id_uses_rt;
    logic          id_ex_mem_read;
    logic [4:0]    id_ex_rt;
    logic          branch_taken;
    logic          imem_ready;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          imem_error;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .LOAD_BUBBLES (LB),
        .IMEM_TIMEOUT (TO),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_uses_rt  (if_id_uses_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .branch_taken   (branch_taken),
        .imem_ready     (imem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .imem_error     (imem_error),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stall cycles still owed, consecutive fetch waits,
    // timeout flag and event totals
    int m_pend  = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare all outputs with the model, advance it
    task automatic drive_cycle(input bit rst_n, input logic [4:0] rs,
                               input logic [4:0] rt, input bit uses,
                               input bit mr, input logic [4:0] lrt,
                               input bit br, input bit rdy);
        bit hz;
        bit [3:0] e;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
        @(negedge clk);
        reset          = rst_n;
        if_id_rs       = rs;
        if_id_rt       = rt;
        if_id_uses_rt  = uses;
        id_ex_mem_read = mr;
        id_ex_rt       = lrt;
        branch_taken   = br;
        imem_ready     = rdy;
        #1;
        hz = mr && (lrt != 0) && ((lrt == rs) || (uses && (lrt == rt)));
        if (!rst_n)                 e = 4'b0011;
        else if (br)                e = 4'b1111;
        else if (hz || m_pend > 0)  e = 4'b0001;
        else if (!rdy)              e = 4'b0110;
        else                        e = 4'b1100;
        check_eq("pc_write",     32'(pc_write),     32'(e[3]));
        check_eq("if_id_write",  32'(if_id_write),  32'(e[2]));
        check_eq("if_id_flush",  32'(if_id_flush),  32'(e[1]));
        check_eq("id_ex_bubble", 32'(id_ex_bubble), 32'(e[0]));
        check_eq("imem_error",   32'(imem_error),   32'(m_err));
        check_eq("stall_count",  32'(stall_count),  32'(m_stall));
        check_eq("flush_count",  32'(flush_count),  32'(m_flush));
        @(posedge clk);
        if (!rst_n) begin
            m_pend = 0; m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[3] && m_stall < CMAX) m_stall++;
            if (br) begin
                m_pend = 0;
                m_wait = 0;
                if (m_flush < CMAX) m_flush++;
            end else if (hz || m_pend > 0) begin
                if (m_pend > 0) m_pend--;
                else            m_pend = LB - 1;
            end else if (!rdy) begin
                if (m_wait < TO) m_wait++;
                if (m_wait == TO) m_err = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b0; if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 1'b0;
        id_ex_mem_read = 1'b0; id_ex_rt = '0; branch_taken = 1'b0;
        imem_ready = 1'b1;

        // Reset held for three cycles, then a normal run cycle
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);

        // Load-use on rs with two bubbles
        drive_cycle(1, 8, 3, 0, 1, 8, 0, 1);
        drive_cycle(1, 8, 3, 0, 1, 8, 0, 1);
        drive_cycle(1, 8, 3, 0, 0, 8, 0, 1);
        #1 check_eq("stall_after_load", 32'(stall_count), 32'd2);

        // Load into $zero never stalls
        drive_cycle(1, 0, 0, 1, 1, 0, 0, 1);
        #1 check_eq("stall_rt_zero", 32'(stall_count), 32'd2);

        // Branch resolves while the load stall is in progress
        drive_cycle(1, 9, 9, 1, 1, 9, 0, 1);
        drive_cycle(1, 9, 9, 1, 1, 9, 1, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        #1 check_eq("flush_after_branch", 32'(flush_count), 32'd1);

        // Five fetch wait cycles against a timeout of three
        for (int i = 1; i <= 5; i++) begin
            drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
            #1 check_eq("imem_error_wait", 32'(imem_error), (i >= TO) ? 32'd1 : 32'd0);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
        #1 check_eq("imem_error_sticky", 32'(imem_error), 32'd1);

        // Hazard and fetch wait together: the load stall wins
        drive_cycle(1, 4, 0, 0, 1, 4, 0, 0);
        drive_cycle(1, 4, 0, 0, 1, 4, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);

        // Long stall drives the narrow counter into saturation
        repeat (20) drive_cycle(1, 7, 0, 0, 1, 7, 0, 1);
        #1 check_eq("stall_saturated", 32'(stall_count), 32'(CMAX));

        // Reset in the middle of a stall leaves no residual bubbles
        drive_cycle(1, 5, 0, 0, 1, 5, 0, 1);
        drive_cycle(0, 5, 0, 0, 1, 5, 0, 1);
        drive_cycle(1, 5, 0, 0, 0, 5, 0, 1);
        #1 check_eq("imem_error_cleared", 32'(imem_error), 32'd0);

        // Random traffic with small register indices to provoke collisions
        for (int n = 0; n < 600; n++) begin
            drive_cycle(($urandom_range(0, 63) != 0),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                        5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
